// File: rtl/apb2reg_bridge_if.sv
// apb2reg_bridge_if: APB3 bus bundle between the interconnect (master) and the bridge (slave)
interface apb2reg_bridge_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;
  modport master(output psel, penable, pwrite, paddr, pwdata, input pready, prdata, pslverr);
  modport slave(input psel, penable, pwrite, paddr, pwdata, output pready, prdata, pslverr);
endinterface

// File: rtl/apb2reg_bridge.sv
// apb2reg_bridge: APB3 slave to native register request bridge; ack timeout built only with APB2REG_TIMEOUT_EN
module apb2reg_bridge #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  apb2reg_bridge_if.slave       apb,
  output logic                  req_vld_o,
  output logic                  wr_en_o,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  input  logic                  ack_vld_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i
);
  localparam int LSB = $clog2(DATA_WIDTH / 8);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic pwrite_q, pwrite_d, req_q, req_d, wr_q, wr_d, rd_q, rd_d, rdy_q, rdy_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic issue, bad, ack, tmo;

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) $error("DATA_WIDTH must be 32 or 64");
  if (TIMEOUT_CYCLES < 1) $error("TIMEOUT_CYCLES must be at least 1");

`ifdef APB2REG_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  assign tmo = state_q == WAIT && !ack_vld_i && cnt_q + CW'(1) == CW'(TIMEOUT_CYCLES);
  // WAIT-cycle counter, cleared on each request; WAIT is left at the limit so it never wraps
  always_ff @(posedge clk) begin
    cnt_q <= (rst || issue) ? '0 : state_q == WAIT ? cnt_q + CW'(1) : cnt_q;
  end
`else
  assign tmo = 1'b0;
`endif

  // next state, request capture and response data/error decisions
  always_comb begin
    issue    = state_q == IDLE && apb.psel && !apb.penable && apb.paddr[LSB-1:0] == '0;
    bad      = state_q == IDLE && apb.psel && !apb.penable && apb.paddr[LSB-1:0] != '0;
    ack      = ack_vld_i && (state_q == REQ || state_q == WAIT);
    state_d  = state_q == IDLE ? (issue ? REQ : bad ? RESP : IDLE) :
               state_q == RESP ? IDLE : (ack || tmo) ? RESP : WAIT;
    pwrite_d = issue ? apb.pwrite : pwrite_q;
    addr_d   = issue ? apb.paddr : addr_q;
    wdata_d  = issue ? apb.pwdata : wdata_q;
    req_d    = issue;
    wr_d     = issue && apb.pwrite;
    rd_d     = issue && !apb.pwrite;
    rdata_d  = ack ? (pwrite_q ? '0 : rd_data_i) : (bad || tmo) ? '0 : rdata_q;
    err_d    = ack ? 1'b0 : (bad || tmo) ? 1'b1 : err_q;
    rdy_d    = state_d == RESP;
  end

  // state and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pwrite_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pwrite_q <= pwrite_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      req_q    <= req_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
      rdy_q    <= rdy_d;
    end
  end

  assign req_vld_o   = req_q;
  assign wr_en_o     = wr_q;
  assign rd_en_o     = rd_q;
  assign addr_o      = addr_q;
  assign wr_data_o   = wdata_q;
  assign apb.pready  = rdy_q;
  assign apb.prdata  = rdata_q;
  assign apb.pslverr = err_q;
endmodule

// File: tb/tb_apb2reg_bridge.sv
// tb_apb2reg_bridge: randomized APB transfers checked cycle by cycle against a transfer-timing model
module tb_apb2reg_bridge;
  localparam int AW = 64, DW = 32, TO = 4;
`ifdef APB2REG_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif
  typedef struct packed {
    logic req, w, rdy, err, dc;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, rd;
    logic [2:0] lk;
    logic lw, le;
    logic [AW-1:0] la;
    logic [DW-1:0] ld;
  } ent_t;
  logic clk = 1'b0, rst = 1'b1, ack_vld = 1'b0, rs = 1'b0, armed = 1'b0;
  logic req_vld, wr_en, rd_en;
  logic [AW-1:0] addr, m_a;
  logic [DW-1:0] wr_data, m_wd, rd_data = '0;
  int cyc = 0, checks = 0, errors = 0;
  ent_t s [4096];
  ent_t e;

  apb2reg_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();
  apb2reg_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .apb(apb),
    .req_vld_o(req_vld), .wr_en_o(wr_en), .rd_en_o(rd_en), .addr_o(addr), .wr_data_o(wr_data),
    .ack_vld_i(ack_vld), .rd_data_i(rd_data)
  );

  always #5 clk = ~clk;

  // cycle counter and the reset value the DUT saw at this edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rs <= rst;
  end

  function automatic logic [11:0] ix(input int c);
    return 12'(c);
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h want %h", n, cyc, act, exp);
    end
  endtask

  // compare every output against the scheduled expectation for this cycle
  always @(negedge clk) begin
    e = s[ix(cyc)];
    if (rs) armed = 1'b1;
    if (armed) begin
      if (rs) begin
        e = '0;
        m_a = '0;
        m_wd = '0;
      end else if (e.req) begin
        m_a = e.a;
        m_wd = e.wd;
      end
      chk("req_vld", 64'(req_vld), 64'(e.req));
      chk("wr_en", 64'(wr_en), 64'(e.req & e.w));
      chk("rd_en", 64'(rd_en), 64'(e.req & ~e.w));
      chk("addr", addr, m_a);
      chk("wr_data", 64'(wr_data), 64'(m_wd));
      chk("pready", 64'(apb.pready), 64'(e.rdy));
      if (rs || e.rdy) chk("pslverr", 64'(apb.pslverr), 64'(e.err));
      if (rs || (e.rdy && !e.dc)) chk("prdata", 64'(apb.prdata), 64'(e.rd));
      if (e.lk == 3'd1) begin
        chk("lit_req", 64'(req_vld), 64'(1));
        chk("lit_wr", 64'(wr_en), 64'(e.lw));
        chk("lit_addr", addr, e.la);
        if (e.lw) chk("lit_wdata", 64'(wr_data), 64'(e.ld));
      end
      if (e.lk == 3'd2 || e.lk == 3'd4) begin
        chk("lit_pready", 64'(apb.pready), 64'(1));
        chk("lit_pslverr", 64'(apb.pslverr), 64'(e.le));
      end
      if (e.lk == 3'd2) chk("lit_prdata", 64'(apb.prdata), 64'(e.ld));
      if (e.lk == 3'd3 || e.lk == 3'd4) chk("lit_noreq", 64'(req_vld), 64'(0));
      if (e.lk == 3'd3) chk("lit_quiet", 64'(apb.pready), 64'(0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    s[ix(cyc + 2048)] = '0;
  endtask

  task automatic lit(input int c, input logic [2:0] k, input logic lw, input logic le,
                     input logic [AW-1:0] la, input logic [DW-1:0] ld);
    s[ix(c)].lk = k;
    s[ix(c)].lw = lw;
    s[ix(c)].le = le;
    s[ix(c)].la = la;
    s[ix(c)].ld = ld;
  endtask

  // transfer-level timing rules: request in T1, response one cycle after ack, after timeout, or in T1 if misaligned
  task automatic plan(input int t0, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input int d, input logic [DW-1:0] rdv, output int p);
    int t1 = t0 + 1;
    if (a[1:0] != 2'b00) begin
      p = t1;
      s[ix(p)].err = 1'b1;
      s[ix(p)].dc = 1'b1;
    end else begin
      s[ix(t1)].req = 1'b1;
      s[ix(t1)].w = w;
      s[ix(t1)].a = a;
      s[ix(t1)].wd = wd;
      if (TEN && (d < 0 || d > TO)) begin
        p = t1 + TO + 1;
        s[ix(p)].err = 1'b1;
        s[ix(p)].rd = '0;
      end else begin
        p = t1 + d + 1;
        s[ix(p)].err = 1'b0;
        s[ix(p)].rd = w ? '0 : rdv;
      end
    end
    s[ix(p)].rdy = 1'b1;
  endtask

  task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd, input int d,
                      input logic [DW-1:0] rdv, input int r, input logic drop);
    int t0, p;
    tick();
    t0 = cyc;
    apb.psel = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite = w;
    apb.paddr = a;
    apb.pwdata = wd;
    ack_vld = 1'b0;
    plan(t0, w, a, wd, d, rdv, p);
    if (r > 0) begin
      s[ix(p)].rdy = 1'b0;
      s[ix(p)].err = 1'b0;
    end
    for (int c = t0 + 1; c <= (r > 0 ? t0 + 1 + r : p); c++) begin
      tick();
      apb.psel = !(drop && c > t0 + 1);
      apb.penable = apb.psel;
      ack_vld = d >= 0 && c == t0 + 1 + d;
      rd_data = ack_vld ? rdv : $urandom;
      rst = r > 0 && c == t0 + 1 + r;
    end
    if (r > 0) begin
      tick();
      rst = 1'b0;
      apb.psel = 1'b0;
      apb.penable = 1'b0;
      ack_vld = 1'b0;
    end
  endtask

  task automatic idle(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      tick();
      apb.psel = 1'b0;
      apb.penable = 1'b0;
      ack_vld = mode == 2 || (mode == 1 && $urandom_range(0, 1) == 1);
      rd_data = $urandom;
    end
  endtask

  initial begin
    int t, d;
    logic w, drop;
    logic [AW-1:0] a;
    for (int i = 0; i < 4096; i++) s[i] = '0;
    apb.psel = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite = 1'b0;
    apb.paddr = '0;
    apb.pwdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    idle(2, 1);
    t = cyc + 1;
    lit(t + 1, 3'd1, 1'b0, 1'b0, 64'h10, '0);
    lit(t + 5, 3'd2, 1'b0, 1'b0, '0, 32'hDEADBEEF);
    xfer(1'b0, 64'h10, $urandom, 3, 32'hDEADBEEF, 0, 1'b0);
    idle(1, 0);
    t = cyc + 1;
    lit(t + 1, 3'd1, 1'b1, 1'b0, 64'h20, 32'h12345678);
    lit(t + 2, 3'd2, 1'b0, 1'b0, '0, '0);
    xfer(1'b1, 64'h20, 32'h12345678, 0, $urandom, 0, 1'b0);
    idle(1, 0);
`ifdef APB2REG_TIMEOUT_EN
    t = cyc + 1;
    lit(t + 6, 3'd2, 1'b0, 1'b1, '0, '0);
    lit(t + 8, 3'd3, 1'b0, 1'b0, '0, '0);
    xfer(1'b0, 64'h30, $urandom, -1, $urandom, 0, 1'b0);
    idle(1, 0);
    idle(1, 2);
    idle(1, 0);
    t = cyc + 1;
    lit(t + 3, 3'd2, 1'b0, 1'b0, '0, 32'hCAFEF00D);
    xfer(1'b0, 64'h40, $urandom, 1, 32'hCAFEF00D, 0, 1'b0);
`else
    t = cyc + 1;
    lit(t + 302, 3'd2, 1'b0, 1'b0, '0, 32'h0BADF00D);
    xfer(1'b0, 64'h30, $urandom, 300, 32'h0BADF00D, 0, 1'b0);
`endif
    idle(1, 0);
    t = cyc + 1;
    lit(t + 1, 3'd4, 1'b0, 1'b1, '0, '0);
    xfer(1'b0, 64'h13, $urandom, 2, $urandom, 0, 1'b0);
    idle(1, 0);
    xfer(1'b0, 64'h50, $urandom, 5, $urandom, 2, 1'b0);
    t = cyc + 1;
    lit(t + 4, 3'd2, 1'b0, 1'b0, '0, 32'h600DCAFE);
    xfer(1'b0, 64'h60, $urandom, 2, 32'h600DCAFE, 0, 1'b0);
    for (int n = 0; n < 300; n++) begin
      w = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      a[1:0] = $urandom_range(0, 7) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
      d = TEN ? int'($urandom_range(0, 7)) - 1 : int'($urandom_range(0, 6));
      drop = $urandom_range(0, 7) == 0;
      xfer(w, a, $urandom, d, $urandom, 0, drop);
      idle(int'($urandom_range(0, 2)), 1);
    end
    idle(3, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
